// File: rtl/m_ext_ctrl_pkg.sv
// m_ext_ctrl_pkg
//   Shared definitions for the RV32M execution sequencer:
//   funct3 codes, sequencer state encoding and the divide
//   special-case constants.
package m_ext_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;
  localparam logic [XLEN-1:0] NEG_ONE    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2,
    S_RESP     = 2'd3
  } state_t;

endpackage

// File: rtl/m_ext_ctrl_div_special.sv
// m_div_special
//   Combinational detection of the divide cases that never reach the
//   divider: zero divisor (any divide/remainder) and signed overflow
//   (INT_MIN / -1 for DIV/REM). Produces the architectural result.
// Ports:
//   i_f3          funct3 of the offered operation
//   i_rs1, i_rs2  dividend, divisor
//   o_bypass      operation is resolved here, skip the divider
//   o_bypass_data result to return when o_bypass is set
module m_div_special
  import m_ext_ctrl_pkg::*;
(
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_bypass,
  output logic [XLEN-1:0] o_bypass_data
);

  logic w_zero;
  logic w_ovf;

  assign w_zero = i_f3[2] & (i_rs2 == '0);
  // Only the signed forms (f3[0]=0) can overflow.
  assign w_ovf  = i_f3[2] & ~i_f3[0] & (i_rs1 == INT_MIN) & (i_rs2 == NEG_ONE);

  assign o_bypass = w_zero | w_ovf;

  // f3[1] separates remainder (1) from quotient (0).
  always_comb begin
    o_bypass_data = '0;
    if (w_zero) begin
      o_bypass_data = i_f3[1] ? i_rs1 : DIV_ZERO_Q;
    end else if (w_ovf) begin
      o_bypass_data = i_f3[1] ? '0 : INT_MIN;
    end
  end

endmodule

// File: rtl/m_ext_ctrl.sv
// m_ext_ctrl
//   Sequencer for the RV32M multiplier/divider. Accepts one operation
//   at a time, latches operands into flops that feed the units, issues a
//   one-cycle start pulse, waits (bounded by MAX_WAIT) for done and
//   returns a registered result. Divide special cases bypass the divider.
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   S_IDLE     | ready for a new operation
//   S_MUL_WAIT | multiplier started, waiting for done or timeout
//   S_DIV_WAIT | divider started, waiting for done or timeout
//   S_RESP     | result held on o_rsp_*, waiting for i_rsp_ready
//
// Ports:
//   i_req_valid/o_req_ready, i_f3, i_rs1, i_rs2   request handshake
//   o_mul_*, i_mul_*                              multiplier interface
//   o_div_*, i_div_*                              divider interface
//   o_rsp_valid/i_rsp_ready, o_rsp_data, o_rsp_err response handshake
module m_ext_ctrl
  import m_ext_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 64
)
(
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_mul_start,
  output logic [32:0]     o_mul_a,
  output logic [32:0]     o_mul_b,
  input  logic            i_mul_done,
  input  logic [63:0]     i_mul_res,
  output logic            o_div_start,
  output logic [XLEN-1:0] o_div_a,
  output logic [XLEN-1:0] o_div_b,
  output logic            o_div_signed,
  input  logic            i_div_done,
  input  logic [XLEN-1:0] i_div_quo,
  input  logic [XLEN-1:0] i_div_rem,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_rsp_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_f3;
  logic [CW-1:0]   r_cnt;
  logic            r_mul_start;
  logic            r_div_start;
  logic            r_div_signed;
  logic            r_rsp_err;
  logic [32:0]     r_mul_a;
  logic [32:0]     r_mul_b;
  logic [XLEN-1:0] r_div_a;
  logic [XLEN-1:0] r_div_b;
  logic [XLEN-1:0] r_rsp_data;
  logic            w_accept;
  logic            w_timeout;
  logic            w_bypass;
  logic [XLEN-1:0] w_bypass_data;

  m_div_special u_div_special (
    .i_f3          (i_f3),
    .i_rs1         (i_rs1),
    .i_rs2         (i_rs2),
    .o_bypass      (w_bypass),
    .o_bypass_data (w_bypass_data)
  );

  assign w_accept  = i_req_valid & (r_state == S_IDLE);
  assign w_timeout = (r_cnt == CW'(MAX_WAIT));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!i_f3[2])      w_next = S_MUL_WAIT;
          else if (w_bypass) w_next = S_RESP;
          else               w_next = S_DIV_WAIT;
        end
      end
      S_MUL_WAIT: if (i_mul_done || w_timeout) w_next = S_RESP;
      S_DIV_WAIT: if (i_div_done || w_timeout) w_next = S_RESP;
      S_RESP:     if (i_rsp_ready) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Done is checked ahead of the timeout so a done arriving in the
  // terminal-count cycle still delivers a real result.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_f3         <= '0;
      r_cnt        <= '0;
      r_mul_start  <= 1'b0;
      r_div_start  <= 1'b0;
      r_div_signed <= 1'b0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_div_a      <= '0;
      r_div_b      <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f3         <= i_f3;
            r_cnt        <= '0;
            r_mul_a      <= {i_rs1[XLEN-1] & ((i_f3 == F3_MULH) || (i_f3 == F3_MULHSU)), i_rs1};
            r_mul_b      <= {i_rs2[XLEN-1] & (i_f3 == F3_MULH), i_rs2};
            r_div_a      <= i_rs1;
            r_div_b      <= i_rs2;
            r_div_signed <= i_f3[2] & ~i_f3[0];
            if (!i_f3[2]) begin
              r_mul_start <= 1'b1;
            end else if (w_bypass) begin
              r_rsp_data <= w_bypass_data;
              r_rsp_err  <= 1'b0;
            end else begin
              r_div_start <= 1'b1;
            end
          end
        end
        S_MUL_WAIT: begin
          if (i_mul_done) begin
            r_rsp_data <= (r_f3 == F3_MUL) ? i_mul_res[31:0] : i_mul_res[63:32];
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DIV_WAIT: begin
          if (i_div_done) begin
            r_rsp_data <= r_f3[1] ? i_div_rem : i_div_quo;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_rsp_valid  = (r_state == S_RESP);
  assign o_mul_start  = r_mul_start;
  assign o_mul_a      = r_mul_a;
  assign o_mul_b      = r_mul_b;
  assign o_div_start  = r_div_start;
  assign o_div_a      = r_div_a;
  assign o_div_b      = r_div_b;
  assign o_div_signed = r_div_signed;
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_m_ext_ctrl.sv
module tb_m_ext_ctrl;

  logic        i_clk;
  logic        i_rstn;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [2:0]  i_f3;
  logic [31:0] i_rs1, i_rs2;
  logic        o_mul_start;
  logic [32:0] o_mul_a, o_mul_b;
  logic        i_mul_done;
  logic [63:0] i_mul_res;
  logic        o_div_start;
  logic [31:0] o_div_a, o_div_b;
  logic        o_div_signed;
  logic        i_div_done;
  logic [31:0] i_div_quo, i_div_rem;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [32:0] cap_mul_a, cap_mul_b;
  logic        cap_div_signed;

  m_ext_ctrl #(.MAX_WAIT(8)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_f3         (i_f3),
    .i_rs1        (i_rs1),
    .i_rs2        (i_rs2),
    .o_mul_start  (o_mul_start),
    .o_mul_a      (o_mul_a),
    .o_mul_b      (o_mul_b),
    .i_mul_done   (i_mul_done),
    .i_mul_res    (i_mul_res),
    .o_div_start  (o_div_start),
    .o_div_a      (o_div_a),
    .o_div_b      (o_div_b),
    .o_div_signed (o_div_signed),
    .i_div_done   (i_div_done),
    .i_div_quo    (i_div_quo),
    .i_div_rem    (i_div_rem),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_err    (o_rsp_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Architectural RV32M reference, computed from the original operands.
  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, r;
    longint unsigned ua, ub, u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ref_m = '0;
    case (f3)
      3'd0: begin u = ua * ub; ref_m = u[31:0]; end
      3'd1: begin r = sa * sb; ref_m = r[63:32]; end
      3'd2: begin r = sa * longint'(ub); ref_m = r[63:32]; end
      3'd3: begin u = ua * ub; ref_m = u[63:32]; end
      3'd4: begin
        if (b == 0) ref_m = 32'hFFFF_FFFF;
        else begin r = sa / sb; ref_m = r[31:0]; end
      end
      3'd5: ref_m = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) ref_m = a;
        else begin r = sa % sb; ref_m = r[31:0]; end
      end
      default: ref_m = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drives one request, plays the unit (done n_done cycles after its
  // start pulse, -1 = never), stalls the response, then hands it off.
  // Latency is counted in cycles after the acceptance edge.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int n_done, input int stall,
                       output int lat, output logic [31:0] data, output logic err,
                       output int mstarts, output int dstarts,
                       output bit stable, output bit busy, output bit ready_after);
    int               start_cyc;
    bit               is_mul;
    logic signed [65:0] p;
    int               sa, sb;
    lat = -1; data = '0; err = 1'b0; mstarts = 0; dstarts = 0;
    stable = 1'b1; busy = 1'b1; ready_after = 1'b0;
    start_cyc = -1; is_mul = 1'b0;
    @(negedge i_clk);
    i_req_valid = 1'b1; i_f3 = f3; i_rs1 = a; i_rs2 = b;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0; i_f3 = 3'($urandom); i_rs1 = $urandom; i_rs2 = $urandom;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      i_mul_done = 1'b0; i_div_done = 1'b0;
      if (o_rsp_valid) begin lat = cyc; break; end
      if (o_mul_start) begin
        mstarts++; start_cyc = cyc; is_mul = 1'b1;
        cap_mul_a = o_mul_a; cap_mul_b = o_mul_b;
      end
      if (o_div_start) begin
        dstarts++; start_cyc = cyc; is_mul = 1'b0;
        cap_div_signed = o_div_signed;
      end
      if (start_cyc >= 0 && n_done >= 0 && cyc == start_cyc + n_done) begin
        if (is_mul) begin
          p = $signed({{33{o_mul_a[32]}}, o_mul_a}) * $signed({{33{o_mul_b[32]}}, o_mul_b});
          i_mul_res = p[63:0]; i_mul_done = 1'b1;
        end else begin
          if (o_div_signed) begin
            sa = o_div_a; sb = o_div_b;
            i_div_quo = sa / sb; i_div_rem = sa % sb;
          end else begin
            i_div_quo = o_div_a / o_div_b; i_div_rem = o_div_a % o_div_b;
          end
          i_div_done = 1'b1;
        end
      end
      @(posedge i_clk); #1;
    end
    i_mul_done = 1'b0; i_div_done = 1'b0;
    if (lat < 0) return;
    data = o_rsp_data; err = o_rsp_err;
    for (int s = 0; s < stall; s++) begin
      if (o_req_ready) busy = 1'b0;
      @(posedge i_clk); #1;
      if (o_rsp_data !== data || o_rsp_err !== err || o_rsp_valid !== 1'b1) stable = 1'b0;
    end
    if (o_req_ready) busy = 1'b0;
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    ready_after = o_req_ready && !o_rsp_valid;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_req_valid = 1'b0; i_f3 = '0; i_rs1 = '0; i_rs2 = '0;
    i_mul_done = 1'b0; i_mul_res = '0; i_div_done = 1'b0; i_div_quo = '0; i_div_rem = '0;
    i_rsp_ready = 1'b0;
    #2;
    checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", o_req_ready); end
    checks++; if ({o_rsp_valid, o_rsp_err, o_mul_start, o_div_start, o_div_signed} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {o_rsp_valid, o_rsp_err, o_mul_start, o_div_start, o_div_signed});
    end
    checks++; if ({o_mul_a, o_mul_b, o_div_a, o_div_b, o_rsp_data} !== '0) begin
      failures++; $display("FAIL reset_data got mul_a=%h div_a=%h rsp=%h exp=0", o_mul_a, o_div_a, o_rsp_data);
    end
    repeat (3) @(posedge i_clk);
    @(negedge i_clk); i_rstn = 1'b1;
  endtask

  task automatic test_mulh();
    int lat, ms, ds; logic [31:0] d; logic e; bit st, bz, ra; exp_t x;
    exp_q.push_back('{data: 32'hFFFF_FFFF, err: 1'b0});
    do_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 3, 0, lat, d, e, ms, ds, st, bz, ra);
    x = exp_q.pop_front();
    checks++; if (cap_mul_a !== 33'h1_FFFF_FFFF) begin failures++; $display("FAIL mulh_mul_a got=%h exp=1ffffffff", cap_mul_a); end
    checks++; if (cap_mul_b !== 33'h0_0000_0002) begin failures++; $display("FAIL mulh_mul_b got=%h exp=000000002", cap_mul_b); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL mulh_latency got=%0d exp=5", lat); end
    checks++; if (d !== x.data || e !== x.err) begin failures++; $display("FAIL mulh_data got=%h/%b exp=%h/%b", d, e, x.data, x.err); end
    checks++; if (ms !== 1 || ds !== 0) begin failures++; $display("FAIL mulh_starts got=%0d/%0d exp=1/0", ms, ds); end
  endtask

  task automatic test_mul_variants();
    int lat, ms, ds, n; logic [31:0] d, a, b; logic e; bit st, bz, ra; exp_t x; logic [2:0] f;
    for (int i = 0; i < 8; i++) begin
      f = 3'(i % 4);
      a = (i == 2) ? 32'h8000_0000 : $urandom;
      b = (i == 6) ? 32'hFFFF_FFFF : $urandom;
      n = (i == 0) ? 0 : $urandom_range(0, 5);
      exp_q.push_back('{data: ref_m(f, a, b), err: 1'b0});
      do_op(f, a, b, n, 0, lat, d, e, ms, ds, st, bz, ra);
      x = exp_q.pop_front();
      checks++; if (d !== x.data || e !== x.err) begin
        failures++; $display("FAIL mul_f3_%0d_data a=%h b=%h got=%h/%b exp=%h/%b", f, a, b, d, e, x.data, x.err);
      end
      checks++; if (lat !== 2 + n) begin failures++; $display("FAIL mul_f3_%0d_latency got=%0d exp=%0d", f, lat, 2 + n); end
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  f3s[6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] as[6]  = '{32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
    logic [31:0] bs[6]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] es[6]  = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    int lat, ms, ds; logic [31:0] d; logic e; bit st, bz, ra; exp_t x;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{data: es[i], err: 1'b0});
      do_op(f3s[i], as[i], bs[i], 2, 0, lat, d, e, ms, ds, st, bz, ra);
      x = exp_q.pop_front();
      checks++; if (d !== x.data || e !== x.err) begin
        failures++; $display("FAIL div_special_%0d_data got=%h/%b exp=%h/%b", i, d, e, x.data, x.err);
      end
      checks++; if (lat !== 1 || ds !== 0 || ms !== 0) begin
        failures++; $display("FAIL div_special_%0d_bypass lat=%0d div_starts=%0d mul_starts=%0d exp=1/0/0", i, lat, ds, ms);
      end
    end
  endtask

  task automatic test_div_stall();
    int lat, ms, ds; logic [31:0] d; logic e; bit st, bz, ra; exp_t x;
    exp_q.push_back('{data: 32'hFFFF_FFFD, err: 1'b0});
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 2, 5, lat, d, e, ms, ds, st, bz, ra);
    x = exp_q.pop_front();
    checks++; if (cap_div_signed !== 1'b1) begin failures++; $display("FAIL div_stall_signed got=%b exp=1", cap_div_signed); end
    checks++; if (d !== x.data || e !== x.err) begin failures++; $display("FAIL div_stall_data got=%h/%b exp=%h/%b", d, e, x.data, x.err); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL div_stall_stable got=%b exp=1", st); end
    checks++; if (bz !== 1'b1) begin failures++; $display("FAIL div_stall_req_ready_low got=%b exp=1", bz); end
    checks++; if (lat !== 4 || ds !== 1) begin failures++; $display("FAIL div_stall_timing lat=%0d starts=%0d exp=4/1", lat, ds); end
  endtask

  task automatic test_div_variants();
    int lat, ms, ds, n; logic [31:0] d, a, b; logic e; bit st, bz, ra; exp_t x; logic [2:0] f;
    for (int i = 0; i < 8; i++) begin
      f = 3'(4 + (i % 4));
      a = $urandom;
      b = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 0) b = 32'd3;
      n = $urandom_range(0, 6);
      exp_q.push_back('{data: ref_m(f, a, b), err: 1'b0});
      do_op(f, a, b, n, 1, lat, d, e, ms, ds, st, bz, ra);
      x = exp_q.pop_front();
      checks++; if (d !== x.data || e !== x.err) begin
        failures++; $display("FAIL div_f3_%0d_data a=%h b=%h got=%h/%b exp=%h/%b", f, a, b, d, e, x.data, x.err);
      end
      checks++; if (cap_div_signed !== ~f[0] || lat !== 2 + n) begin
        failures++; $display("FAIL div_f3_%0d_ctrl signed=%b lat=%0d exp=%b/%0d", f, cap_div_signed, lat, ~f[0], 2 + n);
      end
    end
  endtask

  task automatic test_timeout();
    int lat, ms, ds; logic [31:0] d; logic e; bit st, bz, ra; exp_t x;
    exp_q.push_back('{data: 32'd0, err: 1'b1});
    do_op(3'b000, 32'd5, 32'd6, -1, 2, lat, d, e, ms, ds, st, bz, ra);
    x = exp_q.pop_front();
    checks++; if (d !== x.data || e !== x.err) begin failures++; $display("FAIL timeout_rsp got=%h/%b exp=%h/%b", d, e, x.data, x.err); end
    checks++; if (lat !== 10) begin failures++; $display("FAIL timeout_latency got=%0d exp=10", lat); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL timeout_stable got=%b exp=1", st); end
    @(negedge i_clk); i_mul_done = 1'b1; i_mul_res = 64'hFFFF_0000_1234_5678;
    @(negedge i_clk); i_mul_done = 1'b0;
    repeat (2) @(posedge i_clk); #1;
    checks++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      failures++; $display("FAIL spurious_done valid=%b ready=%b exp=0/1", o_rsp_valid, o_req_ready);
    end
    // done in the terminal-count cycle wins over the timeout
    exp_q.push_back('{data: ref_m(3'b000, 32'd9, 32'd11), err: 1'b0});
    do_op(3'b000, 32'd9, 32'd11, 8, 0, lat, d, e, ms, ds, st, bz, ra);
    x = exp_q.pop_front();
    checks++; if (d !== x.data || e !== x.err || lat !== 10) begin
      failures++; $display("FAIL timeout_done_race got=%h/%b lat=%0d exp=%h/%b lat=10", d, e, lat, x.data, x.err);
    end
  endtask

  task automatic test_back_to_back();
    int lat, ms, ds; logic [31:0] d; logic e; bit st, bz, ra; exp_t x;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{data: ref_m(3'b011, 32'hFFFF_FFFF, 32'(i + 2)), err: 1'b0});
      do_op(3'b011, 32'hFFFF_FFFF, 32'(i + 2), 1, 0, lat, d, e, ms, ds, st, bz, ra);
      x = exp_q.pop_front();
      checks++; if (d !== x.data) begin failures++; $display("FAIL b2b_%0d_data got=%h exp=%h", i, d, x.data); end
      checks++; if (ra !== 1'b1 || bz !== 1'b1) begin failures++; $display("FAIL b2b_%0d_ready ready_after=%b busy=%b exp=1/1", i, ra, bz); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, ms, ds; logic [31:0] d; logic e; bit st, bz, ra; exp_t x;
    @(negedge i_clk);
    i_req_valid = 1'b1; i_f3 = 3'b100; i_rs1 = 32'd100; i_rs2 = 32'd7;
    @(posedge i_clk); #1; i_req_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #3 i_rstn = 1'b0;
    #1;
    checks++; if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_div_start !== 1'b0) begin
      failures++; $display("FAIL reset_mid_flags ready=%b valid=%b start=%b exp=1/0/0", o_req_ready, o_rsp_valid, o_div_start);
    end
    checks++; if ({o_div_a, o_div_b, o_div_signed, o_rsp_data, o_rsp_err} !== '0) begin
      failures++; $display("FAIL reset_mid_data div_a=%h div_b=%h rsp=%h exp=0", o_div_a, o_div_b, o_rsp_data);
    end
    @(negedge i_clk); i_rstn = 1'b1;
    @(negedge i_clk); i_div_done = 1'b1; i_div_quo = 32'd14; i_div_rem = 32'd2;
    @(negedge i_clk); i_div_done = 1'b0;
    repeat (2) @(posedge i_clk); #1;
    checks++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_data !== 32'd0) begin
      failures++; $display("FAIL reset_mid_late_done valid=%b ready=%b data=%h exp=0/1/0", o_rsp_valid, o_req_ready, o_rsp_data);
    end
    exp_q.push_back('{data: 32'd14, err: 1'b0});
    do_op(3'b101, 32'd100, 32'd7, 1, 0, lat, d, e, ms, ds, st, bz, ra);
    x = exp_q.pop_front();
    checks++; if (d !== x.data || e !== x.err) begin failures++; $display("FAIL reset_mid_recover got=%h/%b exp=%h/%b", d, e, x.data, x.err); end
  endtask

  initial begin
    test_reset();
    test_mulh();
    test_mul_variants();
    test_div_special();
    test_div_stall();
    test_div_variants();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
